inst_encoder: RTL and testbench

- Instruction assembler: packs register fields, function fields and a 32-bit signed immediate into a RISC-V instruction word, re-scattering immediate bits per format (I/S/B/U/J/R).
- Inverse of the core's immediate generator; feeds the instruction-memory loader and self-test program builders.
- Valid/ready in, valid/ready out, 1-cycle latency, full throughput via skid buffer.
- Each output beat carries its instruction-memory byte address from an internal counter.

---
 rtl/inst_enc_pkg.sv | 45 ++++
 rtl/inst_encoder_if.sv | 39 +++
 rtl/inst_enc_skid.sv | 69 ++++++
 rtl/inst_encoder.sv | 119 +++++++++++
 tb/tb_inst_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RISC-V instruction encoder.
// Formats, opcodes, immediate range limits and the pipeline beat layout.
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // addi x0, x0, 0 -- substituted for beats that fail the range check
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;

    // Encodable byte-immediate ranges; B/J maxima are even because bit 0 is dropped
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    // One output beat as it travels through the skid buffer
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } beat_t;

    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Handshake bus of the instruction encoder: input request beat, output
// instruction beat, address-load side channel and error counter.
interface inst_encoder_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_fmt;
    logic [6:0]           in_opcode;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [31:0]          in_imm;
    logic                 addr_load;
    logic [31:0]          addr_val;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_inst;
    logic [31:0]          out_addr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Encoder side
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, addr_load, addr_val, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, addr_load, addr_val, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
    );

endinterface

// File: rtl/inst_enc_skid.sv
// Generic valid/ready pipeline stage: one output register plus a one-entry
// skid so the upstream ready never depends combinationally on out_ready.
module inst_enc_skid #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         acc;
    logic         out_free;

    // Ready only from registered state; held low while the skid holds a beat
    assign in_ready = reset_n & ~skid_valid_q;
    assign acc      = in_valid & in_ready;
    assign out_free = ~out_valid_q | out_ready;

    // Next-state: refill output from skid first (ordering), else from input
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // State registers; reset drops any held beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/inst_encoder.sv
// RISC-V instruction assembler: scatters register/function fields and a
// byte immediate into an instruction word, tags it with its byte address and
// emits it through a one-cycle skid stage.
// Build option: define INST_ENC_CHECK_EN to enable the immediate
// range/alignment check, NOP substitution and the saturating error counter.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    inst_encoder_if.slave  bus
);

    logic [31:0] raw_inst;
    logic        chk_err;
    logic        acc;
    logic        skid_in_ready;
    logic [31:0] addr_q, addr_d;
    beat_t       enc_beat;
    beat_t       out_beat;

    assign acc = bus.in_valid & skid_in_ready;

    // Field scatter per format; undefined formats fall back to the R layout
    always_comb begin
        raw_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        case (bus.in_fmt)
            FMT_I: raw_inst = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_S: raw_inst = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               bus.in_imm[4:0], bus.in_opcode};
            FMT_B: raw_inst = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
            FMT_U: raw_inst = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
            FMT_J: raw_inst = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                               bus.in_rd, bus.in_opcode};
            default: ;
        endcase
    end

`ifdef INST_ENC_CHECK_EN
    logic signed [31:0]   imm_s;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign imm_s = $signed(bus.in_imm);

    // Immediate must survive the scatter unchanged; unknown formats always fail
    always_comb begin
        chk_err = 1'b0;
        case (bus.in_fmt)
            FMT_R:        chk_err = 1'b0;
            FMT_I, FMT_S: chk_err = ~in_range(imm_s, IMM12_MIN, IMM12_MAX);
            FMT_B:        chk_err = ~in_range(imm_s, IMM13_MIN, IMM13_MAX) | bus.in_imm[0];
            FMT_U:        chk_err = (bus.in_imm[11:0] != 12'd0);
            FMT_J:        chk_err = ~in_range(imm_s, IMM21_MIN, IMM21_MAX) | bus.in_imm[0];
            default:      chk_err = 1'b1;
        endcase
    end

    // Count accepted errored beats, sticking at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (acc && chk_err && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    // Error counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_cnt_q <= '0;
        else          err_cnt_q <= err_cnt_d;
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign chk_err     = 1'b0;
    assign bus.err_cnt = '0;
`endif

    // Beat assembly; a same-cycle load redirects this beat's address
    always_comb begin
        enc_beat.inst = chk_err ? NOP : raw_inst;
        enc_beat.addr = bus.addr_load ? bus.addr_val : addr_q;
        enc_beat.err  = chk_err;
    end

    // Address counter: advance past an accepted beat, else follow a bare load
    always_comb begin
        addr_d = addr_q;
        if (acc)                addr_d = enc_beat.addr + 32'd4;
        else if (bus.addr_load) addr_d = bus.addr_val;
    end

    // Address counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) addr_q <= BASE_ADDR;
        else          addr_q <= addr_d;
    end

    inst_enc_skid #(
        .W ($bits(beat_t))
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (bus.in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (enc_beat),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_beat)
    );

    assign bus.in_ready = skid_in_ready;
    assign bus.out_inst = out_beat.inst;
    assign bus.out_addr = out_beat.addr;
    assign bus.out_err  = out_beat.err;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed cases plus randomized beats
// with random backpressure, checked against an arithmetic encoding model.
module tb_inst_encoder;
    import inst_enc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          ECW  = 16;
`ifdef INST_ENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    inst_encoder_if #(.ERR_CNT_W(ECW)) bus();

    inst_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nfail = 0;
    logic [31:0] m_addr;
    int          m_errcnt;
    bit          rand_rdy = 1'b0;
    bit          rdy_rand = 1'b1;
    bit          rdy_dir  = 1'b1;

    assign bus.out_ready = rand_rdy ? rdy_rand : rdy_dir;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference: place bit ranges with shifts and masks straight from the format tables
    function automatic void ref_enc(input int fmt, input bit [6:0] op, input bit [4:0] rd,
                                    input bit [4:0] rs1, input bit [4:0] rs2, input bit [2:0] f3,
                                    input bit [6:0] f7, input bit [31:0] u,
                                    output bit [31:0] inst, output bit err);
        int s;
        bit [31:0] o, d, a, b, c, g;
        s = $signed(u);
        o = 32'(op);
        d = 32'(rd) << 7;
        a = 32'(f3) << 12;
        b = 32'(rs1) << 15;
        c = 32'(rs2) << 20;
        g = 32'(f7) << 25;
        err = 1'b0;
        case (fmt)
            0: inst = o | d | a | b | c | g;
            1: begin
                inst = o | d | a | b | ((u & 32'hFFF) << 20);
                err  = (s < -2048) || (s > 2047);
            end
            2: begin
                inst = o | ((u & 32'h1F) << 7) | a | b | c | (((u >> 5) & 32'h7F) << 25);
                err  = (s < -2048) || (s > 2047);
            end
            3: begin
                inst = o | (((u >> 11) & 1) << 7) | (((u >> 1) & 32'hF) << 8) | a | b | c
                         | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 1) << 31);
                err  = (s < -4096) || (s > 4094) || u[0];
            end
            4: begin
                inst = o | d | (u & 32'hFFFF_F000);
                err  = (u & 32'hFFF) != 0;
            end
            5: begin
                inst = o | d | (((u >> 12) & 32'hFF) << 12) | (((u >> 11) & 1) << 20)
                         | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 1) << 31);
                err  = (s < -1048576) || (s > 1048574) || u[0];
            end
            default: begin
                inst = o | d | a | b | c | g;
                err  = 1'b1;
            end
        endcase
        if (!CHK) err = 1'b0;
        if (err) inst = 32'h0000_0013;
    endfunction

    // Drive one beat; push its expectation at the cycle it is accepted
    task automatic send(input int fmt, input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                        input bit [4:0] rs2, input bit [2:0] f3, input bit [6:0] f7, input bit [31:0] imm,
                        input bit ld, input bit [31:0] ldv,
                        input bit use_k, input bit [31:0] k_inst, input bit k_err);
        int   waitc = 0;
        bit   done = 1'b0;
        exp_t e;
        bit [31:0] ei;
        bit   ee;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_fmt    = fmt[2:0];
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.addr_load = ld;
        bus.addr_val  = ldv;
        while (!done) begin
            #1;
            if (bus.in_ready) begin
                ref_enc(fmt, op, rd, rs1, rs2, f3, f7, imm, ei, ee);
                if (use_k) begin
                    ei = k_inst;
                    ee = k_err;
                end
                e.inst = ei;
                e.err  = ee;
                e.addr = ld ? ldv : m_addr;
                m_addr = e.addr + 32'd4;
                if (ee && m_errcnt < (1 << ECW) - 1) m_errcnt++;
                sb.push_back(e);
                done = 1'b1;
                @(posedge clk);
                #1;
                bus.in_valid  = 1'b0;
                bus.addr_load = 1'b0;
            end else begin
                waitc++;
                if (waitc > 200) begin
                    fail_now("send_timeout");
                    done = 1'b1;
                    bus.in_valid  = 1'b0;
                    bus.addr_load = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    // Load the address counter without presenting a beat
    task automatic load_only(input bit [31:0] v);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b1;
        bus.addr_val  = v;
        #1;
        m_addr = v;
        @(posedge clk);
        #1;
        bus.addr_load = 1'b0;
    endtask

    function automatic bit [31:0] rnd_imm();
        int bnd[16] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                        -4097, -1048576, 1048574, 1048576, -1048578, 0, 1, 3};
        bit [31:0] r;
        case ($urandom_range(0, 4))
            0:       r = bnd[$urandom_range(0, 15)];
            1:       r = $urandom_range(0, 8191) - 4096;
            2:       r = $urandom;
            3:       r = $urandom & 32'hFFFF_F000;
            default: r = $urandom_range(0, 2097151) - 1048576;
        endcase
        return r;
    endfunction

    // Random backpressure source
    initial forever begin
        @(negedge clk);
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pop and compare on every output transfer
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                e = sb.pop_front();
                chk("out_inst", bus.out_inst, e.inst);
                chk("out_addr", bus.out_addr, e.addr);
                chk("out_err",  bus.out_err,  e.err);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_fmt    = '0;
        bus.in_opcode = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        bus.addr_load = 1'b0;
        bus.addr_val  = '0;
        m_addr   = BASE;
        m_errcnt = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_inst",  bus.out_inst, 0);
        chk("rst_out_addr",  bus.out_addr, 0);
        chk("rst_out_err",   bus.out_err, 0);
        chk("rst_err_cnt",   bus.err_cnt, 0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // Directed encodings, one-cycle latency
        send(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFF0_0093, 0);
        chk("latency_valid", bus.out_valid, 1);
        send(3, 7'h63, 0, 1, 2, 0, 0, 32'd8, 0, 0, 1, 32'h0020_8463, 0);
        send(3, 7'h63, 0, 1, 2, 0, 0, 32'd9, 0, 0, 1, CHK ? 32'h13 : 32'h0020_8463, CHK);
        chk("err_cnt_b9", bus.err_cnt, CHK ? 1 : 0);
        send(5, 7'h6F, 1, 0, 0, 0, 0, 32'd2048, 0, 0, 1, 32'h0010_00EF, 0);
        send(5, 7'h6F, 1, 0, 0, 0, 0, 32'd1048576, 0, 0, 1, CHK ? 32'h13 : 32'h8000_00EF, CHK);
        chk("err_cnt_j", bus.err_cnt, CHK ? 2 : 0);

        // Reset with output register and skid both full
        repeat (2) @(negedge clk);
        rdy_dir = 1'b0;
        send(0, 7'h33, 5, 6, 7, 1, 7'h20, 0, 0, 0, 0, 0, 0);
        send(2, 7'h23, 0, 3, 4, 2, 0, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
        chk("full_in_ready", bus.in_ready, 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_err_cnt", bus.err_cnt, 0);
        sb.delete();
        m_addr   = BASE;
        m_errcnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        rdy_dir = 1'b1;
        #1;
        chk("postrst_in_ready", bus.in_ready, 1);

        // Stall: 2 beats fill output+skid, 3rd held until release
        rdy_dir = 1'b0;
        send(0, 7'h33, 1, 2, 3, 0, 0, 0, 0, 0, 1, 32'h0031_00B3, 0);
        send(1, 7'h03, 4, 5, 0, 2, 0, 32'd100, 0, 0, 0, 0, 0);
        chk("stall_in_ready", bus.in_ready, 0);
        fork
            send(4, 7'h37, 9, 0, 0, 0, 0, 32'h1234_5000, 0, 0, 0, 0, 0);
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("held_in_ready", bus.in_ready, 0);
                chk("held_out_inst", bus.out_inst, 32'h0031_00B3);
                chk("held_out_addr", bus.out_addr, 0);
                rdy_dir = 1'b1;
            end
        join

        // Address load with acceptance, then wrap
        send(0, 7'h33, 1, 1, 1, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        send(1, 7'h13, 2, 2, 0, 0, 0, 32'd5, 0, 0, 0, 0, 0);
        load_only(32'hFFFF_FFFC);
        send(1, 7'h13, 3, 3, 0, 0, 0, 32'd7, 0, 0, 0, 0, 0);
        send(1, 7'h13, 4, 4, 0, 0, 0, 32'd8, 0, 0, 0, 0, 0);

        // Randomized beats under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) load_only($urandom & 32'hFFFF_FFFC);
            send(CHK ? $urandom_range(0, 7) : $urandom_range(0, 5),
                 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), rnd_imm(),
                 ($urandom_range(0, 15) == 0), $urandom, 0, 0, 0);
        end
        rand_rdy = 1'b0;
        rdy_dir  = 1'b1;

        // Drain
        begin
            int w = 0;
            while (sb.size() != 0 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (sb.size() != 0) fail_now("drain_timeout");
        end
        @(negedge clk);
        #3;
        chk("final_out_valid", bus.out_valid, 0);
        chk("final_err_cnt", bus.err_cnt, 64'(m_errcnt));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
